// File: rtl/cascade_pkg.sv
// Shared types for the detection-window cascade: sweep controller state encoding.
package cascade_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

endpackage : cascade_pkg

// File: rtl/window_sweeper.sv
// Walks a SWEEP_X x SWEEP_Y detection window over a frame, emitting each top-left
// corner through a valid/ready handshake with per-frame latched size and strides.
module window_sweeper
    import cascade_pkg::*;
#(
    parameter int unsigned IMG_WIDTH_MAX  = 320,
    parameter int unsigned IMG_HEIGHT_MAX = 240,
    parameter int unsigned SWEEP_X        = 24,
    parameter int unsigned SWEEP_Y        = 24,
    parameter int unsigned STRIDE_W       = 4,
    localparam int unsigned W_X = $clog2(IMG_WIDTH_MAX + 1),
    localparam int unsigned W_Y = $clog2(IMG_HEIGHT_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [W_X-1:0]      cfg_width,
    input  logic [W_Y-1:0]      cfg_height,
    input  logic [STRIDE_W-1:0] cfg_stride_x,
    input  logic [STRIDE_W-1:0] cfg_stride_y,
    output logic                busy,
    output logic                done,
    output logic                hop_valid,
    input  logic                hop_ready,
    output logic [W_X-1:0]      x_hop,
    output logic [W_Y-1:0]      y_hop,
    output logic                hop_last_x,
    output logic                hop_last
);

    // Limits carry one extra sign bit; look-ahead sums get headroom for the stride.
    localparam int unsigned W_XL = W_X + 1;
    localparam int unsigned W_YL = W_Y + 1;
    localparam int unsigned W_CX = ((W_X > STRIDE_W) ? W_X : STRIDE_W) + 2;
    localparam int unsigned W_CY = ((W_Y > STRIDE_W) ? W_Y : STRIDE_W) + 2;

    sweep_state_e state_q, state_d;

    logic [W_X-1:0]         x_q, x_d;
    logic [W_Y-1:0]         y_q, y_d;
    logic [STRIDE_W-1:0]    sx_q, sx_d;
    logic [STRIDE_W-1:0]    sy_q, sy_d;
    logic signed [W_XL-1:0] xlim_q, xlim_d;
    logic signed [W_YL-1:0] ylim_q, ylim_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic valid_q, valid_d;
    logic last_x_q, last_x_d;
    logic last_q, last_d;

    logic [STRIDE_W-1:0]    sx_in_c;
    logic [STRIDE_W-1:0]    sy_in_c;
    logic signed [W_XL-1:0] xlim_in_c;
    logic signed [W_YL-1:0] ylim_in_c;
    logic signed [W_CX-1:0] nx_c;
    logic signed [W_CY-1:0] ny_c;
    logic                   in_sweep_c;

    // Frame configuration as it would be captured on start.
    always_comb begin
        sx_in_c   = (cfg_stride_x == '0) ? STRIDE_W'(1) : cfg_stride_x;
        sy_in_c   = (cfg_stride_y == '0) ? STRIDE_W'(1) : cfg_stride_y;
        xlim_in_c = $signed({1'b0, cfg_width})  - $signed(W_XL'(SWEEP_X));
        ylim_in_c = $signed({1'b0, cfg_height}) - $signed(W_YL'(SWEEP_Y));
    end

    // Next-state, coordinate stepping and look-ahead of the row/frame end flags.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        xlim_d  = xlim_q;
        ylim_d  = ylim_q;

        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    sx_d   = sx_in_c;
                    sy_d   = sy_in_c;
                    xlim_d = xlim_in_c;
                    ylim_d = ylim_in_c;
                    x_d    = '0;
                    y_d    = '0;
                    if (xlim_in_c[W_XL-1] || ylim_in_c[W_YL-1]) begin
                        state_d = DONE;
                    end else begin
                        state_d = SWEEP;
                    end
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                end else if (valid_q && hop_ready) begin
                    if (last_q) begin
                        state_d = DONE;
                        x_d     = '0;
                        y_d     = '0;
                    end else if (last_x_q) begin
                        x_d = '0;
                        y_d = y_q + W_Y'(sy_q);
                    end else begin
                        x_d = x_q + W_X'(sx_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
            end
        endcase

        // Flags describe the window that will be presented next cycle.
        nx_c       = W_CX'(x_d) + W_CX'(sx_d);
        ny_c       = W_CY'(y_d) + W_CY'(sy_d);
        in_sweep_c = (state_d == SWEEP);

        last_x_d = in_sweep_c && (nx_c > W_CX'(xlim_d));
        last_d   = last_x_d && (ny_c > W_CY'(ylim_d));
        busy_d   = in_sweep_c;
        valid_d  = in_sweep_c;
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            sx_q     <= STRIDE_W'(1);
            sy_q     <= STRIDE_W'(1);
            xlim_q   <= '0;
            ylim_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_x_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            xlim_q   <= xlim_d;
            ylim_q   <= ylim_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            last_x_q <= last_x_d;
            last_q   <= last_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign hop_valid  = valid_q;
    assign x_hop      = x_q;
    assign y_hop      = y_q;
    assign hop_last_x = last_x_q;
    assign hop_last   = last_q;

endmodule : window_sweeper

// File: tb/tb_window_sweeper.sv
// Directed self-checking bench for window_sweeper: full/stride sweeps, degenerate
// sizes, backpressure, abort, config isolation and mid-frame reset.
module tb_window_sweeper;

    localparam int unsigned W_X = 9;
    localparam int unsigned W_Y = 8;
    localparam int unsigned SW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [W_X-1:0] cfg_width;
    logic [W_Y-1:0] cfg_height;
    logic [SW-1:0]  cfg_stride_x;
    logic [SW-1:0]  cfg_stride_y;
    logic           busy;
    logic           done;
    logic           hop_valid;
    logic           hop_ready;
    logic [W_X-1:0] x_hop;
    logic [W_Y-1:0] y_hop;
    logic           hop_last_x;
    logic           hop_last;

    int n_tests = 0;
    int n_fail  = 0;

    window_sweeper dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_stride_x (cfg_stride_x),
        .cfg_stride_y (cfg_stride_y),
        .busy         (busy),
        .done         (done),
        .hop_valid    (hop_valid),
        .hop_ready    (hop_ready),
        .x_hop        (x_hop),
        .y_hop        (y_hop),
        .hop_last_x   (hop_last_x),
        .hop_last     (hop_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h, input int sx, input int sy);
        cfg_width    = W_X'(w);
        cfg_height   = W_Y'(h);
        cfg_stride_x = SW'(sx);
        cfg_stride_y = SW'(sy);
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Runs with ready high until the hop_last handshake; checks the done pulse after it.
    task automatic run_sweep(input int xlim, input int ylim, input int sx, input int sy,
                             inout int hops, output int lx, output int ly,
                             output int rows, output bit done_ok, output bit bad);
        bit fin = 1'b0;
        rows = 0; lx = -1; ly = -1; done_ok = 1'b0; bad = 1'b0;
        hop_ready = 1'b1;
        for (int i = 0; i < 2000 && !fin; i++) begin
            if (hop_valid) begin
                hops++;
                if (int'(x_hop) > xlim || int'(y_hop) > ylim) bad = 1'b1;
                if ((int'(x_hop) % sx) != 0 || (int'(y_hop) % sy) != 0) bad = 1'b1;
                if (hop_last && !hop_last_x) bad = 1'b1;
                if (hop_last_x) rows++;
                if (hop_last) begin
                    lx = int'(x_hop);
                    ly = int'(y_hop);
                    tick();
                    done_ok = done && !hop_valid && !busy;
                    fin = 1'b1;
                end
            end
            if (!fin) tick();
        end
        if (!fin) chk("sweep_timeout", 1, 0);
    endtask

    int  hops, lx, ly, rows;
    bit  done_ok, bad;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hop_ready = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_stride_x = '0; cfg_stride_y = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", hop_valid, 0);
        chk("rst_lastx", hop_last_x, 0);
        chk("rst_last", hop_last, 0);
        chk("rst_xy", {x_hop, y_hop}, 0);
        rst = 1'b0;
        tick();

        // Full sweep, stride 1/1: 18 x 27 windows.
        hop_ready = 1'b1;
        do_start(41, 50, 1, 1);
        chk("full_first_valid", hop_valid, 1);
        chk("full_first_xy", {x_hop, y_hop}, 0);
        chk("full_busy", busy, 1);
        hops = 0;
        run_sweep(17, 26, 1, 1, hops, lx, ly, rows, done_ok, bad);
        chk("full_hops", hops, 486);
        chk("full_last_x", lx, 17);
        chk("full_last_y", ly, 26);
        chk("full_rows", rows, 27);
        chk("full_done", done_ok, 1);
        chk("full_bounds", bad, 0);
        tick();
        chk("full_done_pulse", done, 0);

        // Stride 4/4; cfg changes after start must not affect the frame.
        do_start(41, 50, 4, 4);
        cfg_width = W_X'(100); cfg_height = W_Y'(100);
        cfg_stride_x = SW'(1); cfg_stride_y = SW'(2);
        hops = 0;
        run_sweep(17, 26, 4, 4, hops, lx, ly, rows, done_ok, bad);
        chk("stride_hops", hops, 35);
        chk("stride_last_x", lx, 16);
        chk("stride_last_y", ly, 24);
        chk("stride_rows", rows, 7);
        chk("stride_done", done_ok, 1);
        chk("stride_grid", bad, 0);
        tick();

        // Window wider than image: straight to done.
        do_start(20, 50, 1, 1);
        chk("degen_valid", hop_valid, 0);
        chk("degen_done", done, 1);
        tick();
        chk("degen_done_pulse", done, 0);
        chk("degen_idle_valid", hop_valid, 0);

        // Image equals window: one hop, both last flags.
        do_start(24, 24, 0, 0);
        chk("one_lastx", hop_last_x, 1);
        chk("one_last", hop_last, 1);
        hops = 0;
        run_sweep(0, 0, 1, 1, hops, lx, ly, rows, done_ok, bad);
        chk("one_hops", hops, 1);
        chk("one_xy", lx * 1000 + ly, 0);
        chk("one_done", done_ok, 1);
        tick();

        // Backpressure at (8,0); start during the sweep is ignored.
        hop_ready = 1'b1;
        do_start(41, 50, 4, 4);
        tick(); tick();
        hop_ready = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_x", x_hop, 8);
            chk("bp_y", y_hop, 0);
            chk("bp_valid", hop_valid, 1);
            chk("bp_lastx", hop_last_x, 0);
        end
        start = 1'b0;
        hop_ready = 1'b1;
        tick();
        chk("bp_next_x", x_hop, 12);
        chk("bp_next_lastx", hop_last_x, 0);
        hops = 3;
        run_sweep(17, 26, 4, 4, hops, lx, ly, rows, done_ok, bad);
        chk("bp_hops", hops, 35);
        chk("bp_done", done_ok, 1);
        tick();

        // Abort at hop 10, with cfg stride changed mid-frame.
        do_start(41, 50, 1, 1);
        cfg_stride_x = SW'(3);
        for (int i = 0; i < 10; i++) tick();
        chk("abort_x_at_10", x_hop, 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", hop_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_done_later", done, 0);

        // Abort wins over start in the same cycle.
        abort = 1'b1;
        do_start(41, 50, 1, 1);
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_valid", hop_valid, 0);
        tick();

        // Reset mid-sweep, then restart from origin.
        do_start(41, 50, 1, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_x", x_hop, 5);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", hop_valid, 0);
        chk("mid_rst_x", x_hop, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        do_start(41, 50, 1, 1);
        chk("restart_valid", hop_valid, 1);
        chk("restart_xy", {x_hop, y_hop}, 0);
        hops = 0;
        run_sweep(17, 26, 1, 1, hops, lx, ly, rows, done_ok, bad);
        chk("restart_hops", hops, 486);
        chk("restart_done", done_ok, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_window_sweeper

// File: doc/window_sweeper.md
WINDOW_SWEEPER -- requirements
Module: window_sweeper

Interface
REQ-001 The module SHALL have parameter IMG_WIDTH_MAX, default 320, meaning the largest supported image width in pixels.
REQ-002 The module SHALL have parameter IMG_HEIGHT_MAX, default 240, meaning the largest supported image height in pixels.
REQ-003 The module SHALL have parameter SWEEP_X, default 24, meaning the detection window width.
REQ-004 The module SHALL have parameter SWEEP_Y, default 24, meaning the detection window height.
REQ-005 The module SHALL have parameter STRIDE_W, default 4, meaning the bit width of the stride config ports.
REQ-006 Derived widths SHALL be W_X = $clog2(IMG_WIDTH_MAX+1) and W_Y = $clog2(IMG_HEIGHT_MAX+1).
REQ-007 The module SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-008 The module SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-009 The module SHALL have port start, input, 1 bit: a frame-start request.
REQ-010 The module SHALL have port abort, input, 1 bit: terminates the current sweep.
REQ-011 The module SHALL have port cfg_width, input, W_X bits: the image width.
REQ-012 The module SHALL have port cfg_height, input, W_Y bits: the image height.
REQ-013 The module SHALL have ports cfg_stride_x and cfg_stride_y, input, STRIDE_W bits each: the hop step in x and in y.
REQ-014 The module SHALL have port busy, output, 1 bit: high while in the SWEEP state.
REQ-015 The module SHALL have port done, output, 1 bit: a one-cycle end-of-frame pulse.
REQ-016 The module SHALL have ports hop_valid (output, 1 bit) and hop_ready (input, 1 bit) forming the window handshake.
REQ-017 The module SHALL have ports x_hop (output, W_X bits) and y_hop (output, W_Y bits): the top-left corner of the current window.
REQ-018 The module SHALL have port hop_last_x, output, 1 bit: marks the last window of a row.
REQ-019 The module SHALL have port hop_last, output, 1 bit: marks the last window of the frame.

Function
REQ-020 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-021 FSM transitions SHALL be: IDLE->SWEEP on start; SWEEP->DONE on handshake of hop_last; SWEEP->IDLE on abort; DONE->IDLE unconditionally after 1 cycle.
REQ-022 On start in IDLE, cfg_* SHALL be registered, and later changes to cfg_* SHALL be ignored until the next start.
REQ-023 A stride value of 0 SHALL be treated as 1.
REQ-024 Limits SHALL be X_LIM = cfg_width-SWEEP_X and Y_LIM = cfg_height-SWEEP_Y, computed one bit wider and signed so there is no underflow.
REQ-025 If X_LIM<0 or Y_LIM<0, the FSM SHALL go IDLE->DONE directly, producing zero hops and a done pulse 1 cycle after start.
REQ-026 When start is sampled in cycle N, hop_valid SHALL be high in cycle N+1 with x_hop=0 and y_hop=0.
REQ-027 On a handshake (hop_valid && hop_ready), if x+stride_x<=X_LIM then x SHALL become x+stride_x; otherwise x SHALL become 0 and y SHALL become y+stride_y.
REQ-028 hop_last_x SHALL be high when x+stride_x>X_LIM.
REQ-029 hop_last SHALL be high when hop_last_x is high and y+stride_y>Y_LIM.
REQ-030 Windows SHALL be emitted back-to-back, one per cycle, while hop_ready is held high; there are no bubbles.
REQ-031 While hop_valid && !hop_ready, x_hop, y_hop, hop_last_x and hop_last SHALL hold stable.
REQ-032 hop_valid SHALL be high in SWEEP only, and low in IDLE and DONE.
REQ-033 start in SWEEP or DONE SHALL be ignored.
REQ-034 If abort and start are both high in the same cycle, abort SHALL win.
REQ-035 On abort, hop_valid SHALL be low the next cycle and done SHALL NOT pulse.
REQ-036 done SHALL be high in the DONE state only, which is the cycle after the hop_last handshake.
REQ-037 Coordinates SHALL never exceed the limits: x_hop<=X_LIM and y_hop<=Y_LIM always.

Reset
REQ-038 While rst is high, the FSM SHALL be IDLE, x and y SHALL be 0, and busy, done, hop_valid, hop_last_x and hop_last SHALL be 0.
REQ-039 rst asserted mid-sweep SHALL discard the frame with no done pulse, and the next start SHALL restart from (0,0).

Structure
REQ-040 The state enum (IDLE/SWEEP/DONE) SHALL be defined in the shared package cascade_pkg.
REQ-041 No sub-module SHALL be used; the x/y stride counters SHALL remain inline.

Verification
REQ-042 Full sweep: W=41, H=50, strides 1/1, ready held high -> 486 hops, last hop (17,26) with hop_last=1, done 1 cycle after it.
REQ-043 Stride sweep: W=41, H=50, strides 4/4 -> 35 hops; x in {0,4,8,12,16}; y runs 0..24 in steps of 4; hop_last on (16,24).
REQ-044 Degenerate size: W=20, H=50 -> no hop_valid, done at N+1; W=24, H=24 -> exactly 1 hop (0,0) with hop_last_x=1 and hop_last=1.
REQ-045 Backpressure: hop_ready low for 5 cycles at window (8,0), stride 4 -> outputs stable for 5 cycles, next window (12,0), hop count unchanged.
REQ-046 Abort and reset: abort at hop 10 -> hop_valid low next cycle, no done; cfg change during the sweep has no effect; rst mid-sweep then start -> first hop (0,0).
